// File: rtl/simtop_uart_line_buffer.sv
// simtop_uart_line_buffer
// Collects characters from the SimTop UART output and hands them to the
// console printer one whole line at a time. A line is released on newline,
// when the buffer fills, on an explicit flush, or after an idle timeout.
// Characters arriving while the buffer is full are dropped and counted.
module simtop_uart_line_buffer #(
    parameter int DEPTH       = 16,
    parameter int IDLE_CYCLES = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [7:0]               in_ch,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [7:0]               out_ch,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [$clog2(DEPTH):0]   lines,
    output logic [15:0]              drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(IDLE_CYCLES + 1);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [TW-1:0] IDLE_MAX = TW'(IDLE_CYCLES);

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    localparam logic [7:0] NEWLINE = 8'h0a;

    // Storage: {character, end-of-line flag}
    logic [8:0]    mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] lines_q, lines_d;
    logic [15:0]   drop_q, drop_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [0:0]    state_q, state_d;
    logic          force_q, force_d;

    logic          full_s;
    logic          occ_nz_s;
    logic          push_s;
    logic          pop_s;
    logic          drop_s;
    logic          in_eol_s;
    logic          head_eol_s;
    logic [7:0]    head_ch_s;
    logic          timer_done_s;

    // Handshake and status decode from the registered counters
    always_comb begin
        full_s       = (occ_q == FULL_CNT);
        occ_nz_s     = (occ_q != {CW{1'b0}});
        in_eol_s     = (in_ch == NEWLINE);
        head_ch_s    = mem_q[rd_ptr_q][8:1];
        head_eol_s   = mem_q[rd_ptr_q][0];
        timer_done_s = (timer_q == IDLE_MAX);
        // A full buffer refuses the character even if a pop frees a slot this cycle
        push_s       = in_valid && !full_s;
        drop_s       = in_valid && full_s;
        out_valid    = (state_q == ST_DRAIN) && occ_nz_s;
        pop_s        = out_valid && out_ready;
    end

    // Head entry presented to the printer; forced to zero while empty so reset shows zeros
    always_comb begin
        if (occ_nz_s) begin
            out_ch   = head_ch_s;
            out_last = head_eol_s;
        end else begin
            out_ch   = 8'h00;
            out_last = 1'b0;
        end
    end

    // Next-state for pointers, counters, idle timer and drop counter
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + ONE_CNT;
            2'b01:   occ_d = occ_q - ONE_CNT;
            default: occ_d = occ_q;
        endcase

        case ({push_s && in_eol_s, pop_s && head_eol_s})
            2'b10:   lines_d = lines_q + ONE_CNT;
            2'b01:   lines_d = lines_q - ONE_CNT;
            default: lines_d = lines_q;
        endcase

        if (drop_s && (drop_q != 16'hffff)) begin
            drop_d = drop_q + 16'd1;
        end else begin
            drop_d = drop_q;
        end

        // Timer only measures silence while a partial line sits in FILL
        if (push_s || !occ_nz_s) begin
            timer_d = {TW{1'b0}};
        end else if ((state_q == ST_FILL) && !timer_done_s) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = timer_q;
        end
    end

    // FILL/DRAIN control; force keeps a full/timeout/flush drain running until empty
    always_comb begin
        state_d = state_q;
        force_d = force_q;
        case (state_q)
            ST_FILL: begin
                if (occ_nz_s && ((lines_q != {CW{1'b0}}) || full_s || flush || timer_done_s)) begin
                    state_d = ST_DRAIN;
                    force_d = full_s || flush || timer_done_s;
                end else begin
                    state_d = ST_FILL;
                    force_d = force_q;
                end
            end
            ST_DRAIN: begin
                if (pop_s && !push_s && (occ_q == ONE_CNT)) begin
                    state_d = ST_FILL;
                    force_d = 1'b0;
                end else if (pop_s && head_eol_s && (lines_d == {CW{1'b0}}) && !flush && !force_q) begin
                    state_d = ST_FILL;
                    force_d = 1'b0;
                end else begin
                    state_d = ST_DRAIN;
                    force_d = force_q;
                end
            end
            default: begin
                state_d = ST_FILL;
                force_d = 1'b0;
            end
        endcase
    end

    // Control and counter registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            occ_q    <= {CW{1'b0}};
            lines_q  <= {CW{1'b0}};
            drop_q   <= 16'h0000;
            timer_q  <= {TW{1'b0}};
            state_q  <= ST_FILL;
            force_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            lines_q  <= lines_d;
            drop_q   <= drop_d;
            timer_q  <= timer_d;
            state_q  <= state_d;
            force_q  <= force_d;
        end
    end

    // Character storage; contents need no reset because occupancy gates the head
    always_ff @(posedge clock) begin
        if (push_s && reset) begin
            mem_q[wr_ptr_q] <= {in_ch, in_eol_s};
        end
    end

    assign occupancy  = occ_q;
    assign lines      = lines_q;
    assign drop_count = drop_q;

endmodule

// File: doc/simtop_uart_line_buffer.md
# simtop_uart_line_buffer

Buffers the character stream from SimTop's UART output port (`io_uart_out_valid` / `io_uart_out_ch`) and releases it to the testbench console printer a whole line at a time. This keeps console output from interleaving with other simulation messages. It sits between the DUT UART output and the testbench's `$fwrite` print logic. It drains on newline, FIFO full, an explicit flush, or an idle timeout, and it counts characters dropped on overflow.

## Interface
Parameters:
- `DEPTH`, default 16: FIFO entries. Must be a power of 2, at least 2.
- `IDLE_CYCLES`, default 1024: idle cycles after the last push before a partial line is drained. Must be at least 1.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  character strobe from the DUT UART. No backpressure to the DUT.
- `in_ch`  in  8  character.
- `flush`  in  1  force drain of everything buffered (end-of-sim).
- `out_valid`  out  1  character available to the printer.
- `out_ch`  out  8  head character.
- `out_last`  out  1  head character is 8'h0a (end of line).
- `out_ready`  in  1  printer accepts the head character this cycle.
- `occupancy`  out  $clog2(DEPTH)+1  entries currently stored.
- `lines`  out  $clog2(DEPTH)+1  stored entries whose character is 8'h0a.
- `drop_count`  out  16  characters dropped on overflow. Saturates at 16'hffff.

## Operation
- Storage: circular FIFO of {ch[7:0], eol}, where eol = (ch == 8'h0a).
  - Read and write pointers are $clog2(DEPTH) bits wide and wrap naturally.
  - `occupancy` is a separate counter.
- Push: occurs when `in_valid` && `occupancy` != DEPTH, using `occupancy` as registered before any same-cycle pop.
  - A full FIFO drops the character even if a pop happens in the same cycle.
  - Each drop increments `drop_count`, saturating.
- Pop: occurs when `out_valid` && `out_ready`.
- Counter updates:
  - `occupancy` changes by push − pop.
  - `lines` changes by (push && eol_in) − (pop && eol_head).
  - Simultaneous push and pop leave the counters balanced.
- Idle timer:
  - Cleared on every push, and while the FIFO is empty.
  - Otherwise increments while state is FILL, saturating at IDLE_CYCLES.
- FSM has two states, FILL and DRAIN:
  - FILL: `out_valid`=0. Go to DRAIN when `occupancy` != 0 and at least one of the following holds: `lines` != 0, `occupancy` == DEPTH, `flush`, or timer == IDLE_CYCLES.
  - DRAIN: `out_valid` = (`occupancy` != 0). Return to FILL on a pop that leaves the FIFO empty (pop with no push and `occupancy`==1).
  - DRAIN also returns to FILL on a pop of an eol entry that leaves `lines`==0, when `flush` is low and the drain was not started by full or timeout.
  - A sticky `force` bit records a drain started by full, timeout or flush. It is cleared on return to FILL.
  - While `force`=1, DRAIN ends only when the FIFO empties.
- `out_ch` / `out_last` always reflect the head entry. They are don't-care when `occupancy`==0.
- `flush` held high keeps the block in DRAIN behaviour: characters pass through with a one-cycle FIFO latency.

## Timing
- Reset is sampled at the rising edge while `reset`==0. Reset values:
  - `out_valid`=0, `out_ch`=0, `out_last`=0.
  - `occupancy`=0, `lines`=0, `drop_count`=0.
  - State FILL, timer=0, `force`=0, pointers=0.
- Reset asserted mid-drain discards all buffered characters. No output in that cycle after the edge.
- Push at edge e updates the counters after e. The FSM evaluates the registered counters, so the state becomes DRAIN at edge e+1. The first `out_valid` is visible after e+1.
  - Newline-to-first-character latency: 2 clocks.
- Drain throughput: 1 character/clock while `out_ready`=1.
- Idle drain: with no pushes, the state becomes DRAIN IDLE_CYCLES+1 edges after the last push.
- `out_valid` is combinational from state and `occupancy` only. It does not depend on `out_ready`.

## Test plan
- Push "hi\n" on 3 consecutive cycles with `out_ready`=1:
  - `out_valid` stays 0 through the cycle after the '\n' push.
  - Then 'h','i','\n' come out on 3 consecutive cycles, with `out_last`=1 only on '\n'.
  - FSM returns to FILL; `occupancy`=0, `lines`=0.
- Push 20 non-newline characters back-to-back, DEPTH=16, `out_ready`=0:
  - `occupancy` reaches 16, `drop_count`=4.
  - Then raise `out_ready`: all 16 characters drain in order, and DRAIN persists until empty (force).
- Push "ab" then idle, IDLE_CYCLES=8:
  - No output for 8 cycles.
  - 'a','b' emitted starting 9 edges after the last push.
  - Timer is cleared if 'c' is pushed at cycle 5.
- Push "x\ny\nz", `out_ready`=1:
  - 'x','\n' emitted, then 'y','\n'.
  - 'z' is retained in FILL until the timeout or `flush`.
- Full FIFO, `in_valid` and pop in the same cycle: the character is dropped, `drop_count`+1, `occupancy` goes 16→15.
- Drive `reset`=0 mid-drain with 5 entries stored: the next cycle shows `out_valid`=0, `occupancy`=0, `drop_count`=0, and the state is FILL.
